load_store_unit: RTL and testbench

Pipeline-side memory stage placed directly upstream of the data `cache`. It converts RV32 byte, halfword and word loads and stores into the cache's word-only read/write handshake. Sub-word loads are sign- or zero-extended. Sub-word stores use a read-modify-write. Misaligned and illegal accesses are trapped with no cache traffic. The pipeline stalls on `stall` until the access retires.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_cache_if.sv | 37 +++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - state_t      : FSM state encoding
//   - F3_*         : RV32 load/store width codes (funct3)
//   - access_fault : returns 1 for a request that must trap without cache traffic
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A request traps when it asks for both a load and a store, uses a width
  // code that is undefined for its direction (BU/HU are load-only), or is
  // not naturally aligned for its width.
  function automatic logic access_fault(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic flt;
    flt = 1'b0;
    if (rd && wr) begin
      flt = 1'b1;
    end else begin
      case (f3)
        F3_B:    flt = 1'b0;
        F3_H:    flt = addr_lo[0];
        F3_W:    flt = (addr_lo != 2'b00);
        F3_BU:   flt = wr;
        F3_HU:   flt = wr | addr_lo[0];
        default: flt = 1'b1;
      endcase
    end
    return flt;
  endfunction

endpackage

// File: rtl/lsu_cache_if.sv
// lsu_cache_if: word-only read/write handshake between the load/store unit
// and the data cache.
//   cache_read_en / cache_write_en : request strobes (never high together)
//   cache_addr                     : word-aligned byte address
//   cache_write_data               : full word to write
//   cache_read_data                : word returned by the cache
//   cache_busywait                 : cache not ready; request must be held
// modport master : load/store unit side
// modport slave  : cache side
interface lsu_cache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cache_read_en;
  logic                  cache_write_en;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [31:0]           cache_write_data;
  logic [31:0]           cache_read_data;
  logic                  cache_busywait;

  modport master (
    output cache_read_en,
    output cache_write_en,
    output cache_addr,
    output cache_write_data,
    input  cache_read_data,
    input  cache_busywait
  );

  modport slave (
    input  cache_read_en,
    input  cache_write_en,
    input  cache_addr,
    input  cache_write_data,
    output cache_read_data,
    output cache_busywait
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane logic for the load/store unit.
//   chk_read/chk_write/chk_funct3/chk_addr_lo -> chk_fault : trap detect on the
//     live request
//   funct3/addr_lo : captured width code and low address bits
//   rd_word        : word returned by the cache
//   wr_half        : low half of the captured store operand
//   load_ext       : selected lane, sign- or zero-extended
//   merged         : rd_word with the store byte/half inserted (little-endian)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        chk_read,
  input  logic        chk_write,
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_addr_lo,
  output logic        chk_fault,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [15:0] wr_half,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    chk_fault = access_fault(chk_read, chk_write, chk_funct3, chk_addr_lo);
  end

  always_comb begin
    lane_b = rd_word[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_ext = {24'h000000, lane_b};
      F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_ext = {16'h0000, lane_h};
      default: load_ext = rd_word;
    endcase
  end

  always_comb begin
    merged = rd_word;
    if (funct3 == F3_B) begin
      merged[{addr_lo, 3'b000} +: 8] = wr_half[7:0];
    end else begin
      merged[{addr_lo[1], 4'b0000} +: 16] = wr_half;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: pipeline memory stage in front of a word-only data cache.
// Turns RV32 B/H/W/BU/HU loads and stores into cache word reads/writes;
// sub-word stores are done as read-modify-write, misaligned or illegal
// requests trap straight to DONE without touching the cache.
//   clock, reset          : clock, asynchronous active-high reset
//   mem_read, mem_write   : request strobes, held until stall drops
//   funct3, address       : width code and byte address
//   store_data            : store operand (low byte/half used for B/H)
//   load_data, fault      : registered results, valid while stall is low in DONE
//   stall                 : holds the pipeline while a request is unretired
//   cache                 : master side of the cache handshake
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  stall,
  output logic                  fault,
  lsu_cache_if.master           cache
);

  state_t      state;
  logic        req;
  logic        req_fault;
  logic [2:0]  f3_p0;
  logic [1:0]  addr_lo_p0;
  logic [15:0] wr_half_p0;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        done_hs;

  assign req     = mem_read | mem_write;
  assign stall   = ((state == ST_IDLE) && req) ||
                   ((state != ST_IDLE) && (state != ST_DONE));
  assign done_hs = ~cache.cache_busywait;

  lsu_lane_align u_lane (
    .chk_read    (mem_read),
    .chk_write   (mem_write),
    .chk_funct3  (funct3),
    .chk_addr_lo (address[1:0]),
    .chk_fault   (req_fault),
    .funct3      (f3_p0),
    .addr_lo     (addr_lo_p0),
    .rd_word     (cache.cache_read_data),
    .wr_half     (wr_half_p0),
    .load_ext    (load_ext),
    .merged      (merged)
  );

  // Request capture: only the fields needed after IDLE are kept; the word
  // address goes straight into cache_addr.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && req) begin
      f3_p0      <= funct3;
      addr_lo_p0 <= address[1:0];
      wr_half_p0 <= store_data[15:0];
    end
  end

  // Control FSM; the cache strobes, address and write word are registered so
  // they stay constant for the whole state and drop on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      load_data              <= 32'h0;
      fault                  <= 1'b0;
      cache.cache_read_en    <= 1'b0;
      cache.cache_write_en   <= 1'b0;
      cache.cache_addr       <= '0;
      cache.cache_write_data <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            load_data <= 32'h0;
            if (req_fault) begin
              fault <= 1'b1;
              state <= ST_DONE;
            end else begin
              fault            <= 1'b0;
              cache.cache_addr <= {address[ADDR_WIDTH-1:2], 2'b00};
              if (mem_read) begin
                cache.cache_read_en <= 1'b1;
                state               <= ST_LOAD;
              end else if (funct3 == F3_W) begin
                cache.cache_write_en   <= 1'b1;
                cache.cache_write_data <= store_data;
                state                  <= ST_STORE;
              end else begin
                cache.cache_read_en <= 1'b1;
                state               <= ST_RMW_RD;
              end
            end
          end
        end
        ST_LOAD: begin
          if (done_hs) begin
            load_data           <= load_ext;
            cache.cache_read_en <= 1'b0;
            state               <= ST_DONE;
          end
        end
        ST_STORE: begin
          if (done_hs) begin
            cache.cache_write_en <= 1'b0;
            state                <= ST_DONE;
          end
        end
        ST_RMW_RD: begin
          // Swap read for write in one edge so the strobes never overlap.
          if (done_hs) begin
            cache.cache_read_en    <= 1'b0;
            cache.cache_write_en   <= 1'b1;
            cache.cache_write_data <= merged;
            state                  <= ST_RMW_WR;
          end
        end
        ST_RMW_WR: begin
          if (done_hs) begin
            cache.cache_write_en <= 1'b0;
            state                <= ST_DONE;
          end
        end
        ST_DONE: begin
          fault <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          cache.cache_read_en  <= 1'b0;
          cache.cache_write_en <= 1'b0;
          state                <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        flt;
    int          stall_n;
    int          rd_n;
    int          wr_n;
    int          en_n;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        fault;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  lsu_cache_if #(.ADDR_WIDTH(32)) cif ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .fault      (fault),
    .cache      (cif)
  );

  always #5 clock = ~clock;

  // Cache model: 64 words, combinational read, write on a completed edge.
  logic [31:0] mem [0:63] = '{4: 32'hDEADBEEF, 8: 32'h11223344,
                              10: 32'h55667788, default: 32'h0};
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          en_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  bit          both_seen = 1'b0;

  assign cif.cache_read_data = mem[cif.cache_addr[7:2]];

  always @(posedge clock) begin
    if (cif.cache_read_en && !cif.cache_busywait) rd_cnt <= rd_cnt + 1;
    if (cif.cache_write_en && !cif.cache_busywait) begin
      wr_cnt                   <= wr_cnt + 1;
      mem[cif.cache_addr[7:2]] <= cif.cache_write_data;
      last_wr_addr             <= cif.cache_addr;
    end
  end

  always @(negedge clock) begin
    if (cif.cache_read_en || cif.cache_write_en) en_cnt <= en_cnt + 1;
    if (cif.cache_read_en && cif.cache_write_en) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request (called #1 after a rising edge), count stall cycles,
  // optionally hold busywait for busy_n cycles, and check the result in DONE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input int busy_n, input exp_t e);
    int   n;
    int   left;
    int   rd0;
    int   wr0;
    int   en0;
    bit   done;
    bit   stable;
    exp_t x;
    sb.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt; en0 = en_cnt;
    n = 0; left = busy_n; done = 1'b0; stable = 1'b1;
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = sdata;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      if (!stall) begin
        done = 1'b1;
      end else begin
        n++;
        if (i >= 1) begin
          if (cif.cache_addr !== {addr[31:2], 2'b00} ||
              !(cif.cache_read_en ^ cif.cache_write_en)) stable = 1'b0;
          cif.cache_busywait = (left > 0);
          if (left > 0) left--;
        end
      end
    end
    chk({tag, "_retired"}, {31'b0, done}, 32'd1);
    if (done && sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_stall_cycles"}, n, x.stall_n);
      chk({tag, "_load_data"}, load_data, x.data);
      chk({tag, "_fault"}, {31'b0, fault}, {31'b0, x.flt});
      chk({tag, "_reads"}, rd_cnt - rd0, x.rd_n);
      chk({tag, "_writes"}, wr_cnt - wr0, x.wr_n);
      chk({tag, "_enable_cycles"}, en_cnt - en0, x.en_n);
      chk({tag, "_bus_stable"}, {31'b0, stable}, 32'd1);
    end
    @(posedge clock);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; cif.cache_busywait = 1'b0;
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic f, input int st,
                              input int r, input int w, input int en);
    exp_t e;
    e.data = d; e.flt = f; e.stall_n = st; e.rd_n = r; e.wr_n = w; e.en_n = en;
    return e;
  endfunction

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    address = 32'h0; store_data = 32'h0; cif.cache_busywait = 1'b0;
    #3;
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_read_en", {31'b0, cif.cache_read_en}, 32'd0);
    chk("rst_write_en", {31'b0, cif.cache_write_en}, 32'd0);
    chk("rst_cache_addr", cif.cache_addr, 32'h0);
    chk("rst_write_data", cif.cache_write_data, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    mem_read = 1'b1; #1;
    chk("rst_stall_follows_req", {31'b0, stall}, 32'd1);
    mem_read = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    access("lw_hit", 1, 0, F3_W, 32'h10, 32'h0, 0, mk(32'hDEADBEEF, 0, 2, 1, 0, 1));
    access("sw_hit", 0, 1, F3_W, 32'h10, 32'h80FF7F01, 0, mk(32'h0, 0, 2, 0, 1, 1));
    chk("sw_mem", mem[4], 32'h80FF7F01);
    access("lb", 1, 0, F3_B, 32'h13, 32'h0, 0, mk(32'hFFFFFF80, 0, 2, 1, 0, 1));
    access("lbu", 1, 0, F3_BU, 32'h13, 32'h0, 0, mk(32'h00000080, 0, 2, 1, 0, 1));
    access("lh", 1, 0, F3_H, 32'h12, 32'h0, 0, mk(32'hFFFF80FF, 0, 2, 1, 0, 1));
    access("lhu", 1, 0, F3_HU, 32'h12, 32'h0, 0, mk(32'h000080FF, 0, 2, 1, 0, 1));
    access("lb_lane0", 1, 0, F3_B, 32'h10, 32'h0, 0, mk(32'h00000001, 0, 2, 1, 0, 1));
    access("sb", 0, 1, F3_B, 32'h21, 32'h000000AB, 0, mk(32'h0, 0, 3, 1, 1, 2));
    chk("sb_mem", mem[8], 32'h1122AB44);
    chk("sb_wr_addr", last_wr_addr, 32'h20);
    access("sh", 0, 1, F3_H, 32'h22, 32'h1234BEEF, 0, mk(32'h0, 0, 3, 1, 1, 2));
    chk("sh_mem", mem[8], 32'hBEEFAB44);
    access("lw_merged", 1, 0, F3_W, 32'h20, 32'h0, 0, mk(32'hBEEFAB44, 0, 2, 1, 0, 1));
    access("lw_busy", 1, 0, F3_W, 32'h10, 32'h0, 5, mk(32'h80FF7F01, 0, 7, 1, 0, 6));
    access("sh_misal", 0, 1, F3_H, 32'h31, 32'h5555, 0, mk(32'h0, 1, 1, 0, 0, 0));
    access("lw_misal", 1, 0, F3_W, 32'h32, 32'h0, 0, mk(32'h0, 1, 1, 0, 0, 0));
    access("lhu_misal", 1, 0, F3_HU, 32'h11, 32'h0, 0, mk(32'h0, 1, 1, 0, 0, 0));
    access("ld_illegal", 1, 0, 3'b011, 32'h10, 32'h0, 0, mk(32'h0, 1, 1, 0, 0, 0));
    access("sbu_illegal", 0, 1, F3_BU, 32'h10, 32'h0, 0, mk(32'h0, 1, 1, 0, 0, 0));
    access("rd_and_wr", 1, 1, F3_W, 32'h10, 32'h0, 0, mk(32'h0, 1, 1, 0, 0, 0));
    chk("fault_mem_intact", mem[4], 32'h80FF7F01);

    // Reset while the RMW write is stalled by busywait.
    begin
      int wr0;
      mem_write = 1'b1; funct3 = F3_B; address = 32'h28; store_data = 32'hEE;
      @(posedge clock); #1;
      @(posedge clock); #1;
      cif.cache_busywait = 1'b1;
      wr0 = wr_cnt;
      chk("rmw_wr_en", {31'b0, cif.cache_write_en}, 32'd1);
      @(posedge clock); #2;
      mem_write = 1'b0;
      reset = 1'b1; #1;
      chk("rmwrst_write_en", {31'b0, cif.cache_write_en}, 32'd0);
      chk("rmwrst_read_en", {31'b0, cif.cache_read_en}, 32'd0);
      chk("rmwrst_stall", {31'b0, stall}, 32'd0);
      @(negedge clock); reset = 1'b0; cif.cache_busywait = 1'b0;
      @(posedge clock); #1;
      chk("rmwrst_no_write", wr_cnt - wr0, 32'd0);
      chk("rmwrst_mem", mem[10], 32'h55667788);
    end
    access("lw_after_rst", 1, 0, F3_W, 32'h28, 32'h0, 0, mk(32'h55667788, 0, 2, 1, 0, 1));

    chk("enables_exclusive", {31'b0, both_seen}, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
